// File: rtl/otp_stream_decryptor.sv
// otp_stream_decryptor: serial one-time-pad decryptor with byte deserializer.
// Optional even-parity frame bit over ciphertext enabled by OTP_PARITY_EN.
module otp_stream_decryptor #(
    parameter int               KEY_W = 16,
    parameter logic [KEY_W-1:0] TAPS  = 16'hB400
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [KEY_W-1:0] seed,
    input  logic             cipher_bit,
    input  logic             cipher_valid,
    output logic [7:0]       plain_byte,
    output logic             plain_valid,
    input  logic             plain_ready,
    output logic             busy,
`ifdef OTP_PARITY_EN
    output logic             parity_err,
`endif
    output logic             overrun
);

`ifdef OTP_PARITY_EN
    localparam int            CW   = 4;
    localparam logic [CW-1:0] LAST = 4'd8;
`else
    localparam int            CW   = 3;
    localparam logic [CW-1:0] LAST = 3'd7;
`endif

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [KEY_W-1:0] r_lfsr;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_sh;
    logic             r_par;

    logic             w_consume;
    logic             w_data;
    logic             w_done;
    logic             w_free;
    logic             w_p;
    logic [7:0]       w_byte;
    logic [KEY_W-1:0] w_seed;
    logic [KEY_W-1:0] w_lfsr_nx;

    // A start in RUN restarts the stream, so the bit on that cycle is ignored.
    assign w_consume = (r_state == S_RUN) && cipher_valid && !start;
    assign w_p       = cipher_bit ^ r_lfsr[0];
    assign w_done    = w_consume && (r_cnt == LAST);
    assign w_free    = !plain_valid || plain_ready;
    assign w_seed    = (seed == '0) ? {{(KEY_W-1){1'b0}}, 1'b1} : seed;
    assign w_lfsr_nx = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
    assign busy      = (r_state == S_RUN);

`ifdef OTP_PARITY_EN
    // The 9th bit is the parity bit: not decrypted, no keystream step.
    assign w_data = (r_cnt != LAST);
    assign w_byte = r_sh;
`else
    assign w_data = 1'b1;
    assign w_byte = {w_p, r_sh[6:0]};
`endif

    // Next-state logic: start has priority over stop.
    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = S_RUN;
        end else if (stop) begin
            w_state_nx = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Keystream, bit counter, shift register and running ciphertext parity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= {{(KEY_W-1){1'b0}}, 1'b1};
            r_cnt  <= '0;
            r_sh   <= '0;
            r_par  <= 1'b0;
        end else if (start) begin
            r_lfsr <= w_seed;
            r_cnt  <= '0;
            r_sh   <= '0;
            r_par  <= 1'b0;
        end else if (w_consume) begin
            r_cnt <= w_done ? '0 : r_cnt + 1'b1;
            if (w_data) begin
                r_lfsr           <= w_lfsr_nx;
                r_sh[r_cnt[2:0]] <= w_p;
                r_par            <= r_par ^ cipher_bit;
            end
            if (w_done) begin
                r_par <= 1'b0;
            end
        end
    end

    // Output holding register, handshake and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            plain_byte  <= 8'h00;
            plain_valid <= 1'b0;
            overrun     <= 1'b0;
`ifdef OTP_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            if (w_done && w_free) begin
                plain_byte  <= w_byte;
                plain_valid <= 1'b1;
            end else if (plain_valid && plain_ready) begin
                plain_valid <= 1'b0;
            end
            if (w_done && !w_free) begin
                overrun <= 1'b1;
            end
`ifdef OTP_PARITY_EN
            if (w_done && (r_par ^ cipher_bit)) begin
                parity_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_otp_stream_decryptor.sv
// tb_otp_stream_decryptor: directed scoreboard bench for otp_stream_decryptor.
// Parity-frame steps are included when OTP_PARITY_EN is defined.
module tb_otp_stream_decryptor;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] seed;
    logic        cipher_bit;
    logic        cipher_valid;
    logic [7:0]  plain_byte;
    logic        plain_valid;
    logic        plain_ready;
    logic        busy;
    logic        overrun;
`ifdef OTP_PARITY_EN
    logic        parity_err;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  q[$];
    logic [15:0] m_lfsr;
    logic        m_pbad = 1'b0;
    logic [7:0]  held;

    always #5 clk = ~clk;

    otp_stream_decryptor #(.KEY_W(16), .TAPS(16'hB400)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .seed         (seed),
        .cipher_bit   (cipher_bit),
        .cipher_valid (cipher_valid),
        .plain_byte   (plain_byte),
        .plain_valid  (plain_valid),
        .plain_ready  (plain_ready),
        .busy         (busy),
`ifdef OTP_PARITY_EN
        .parity_err   (parity_err),
`endif
        .overrun      (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference keystream: Galois LFSR, 8 steps per byte, LSB first.
    task automatic keybyte(output logic [7:0] k);
        for (int i = 0; i < 8; i++) begin
            k[i] = m_lfsr[0];
            if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
            else           m_lfsr = m_lfsr >> 1;
        end
    endtask

    task automatic do_start(input logic [15:0] s);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        m_lfsr = (s == 16'h0) ? 16'h1 : s;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic lat);
        logic [7:0] k;
        keybyte(k);
        q.push_back(c ^ k);
        for (int i = 0; i < 8; i++) begin
            if (lat && i == 7) chk("lat_pre", plain_valid, 1'b0);
            cipher_bit   = c[i];
            cipher_valid = 1'b1;
            tick();
        end
`ifdef OTP_PARITY_EN
        if (lat) chk("lat_pre_par", plain_valid, 1'b0);
        cipher_bit = (^c) ^ m_pbad;
        tick();
`endif
        cipher_valid = 1'b0;
        cipher_bit   = 1'b0;
        if (lat) chk("lat_post", plain_valid, 1'b1);
    endtask

    task automatic expect_out(input string tag);
        int         n;
        logic [7:0] exp;
        n = 0;
        while (!plain_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, plain_valid, 1'b1);
        exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
        chk(tag, plain_byte, exp);
    endtask

    task automatic accept();
        plain_ready = 1'b1;
        tick();
        plain_ready = 1'b0;
        chk("valid_clr", plain_valid, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stop         = 1'b0;
        seed         = 16'h0;
        cipher_bit   = 1'b0;
        cipher_valid = 1'b0;
        plain_ready  = 1'b0;
        m_lfsr       = 16'h1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_valid", plain_valid, 1'b0);
        chk("rst_byte", plain_byte, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
`ifdef OTP_PARITY_EN
        chk("rst_par", parity_err, 1'b0);
`endif

        // First byte with seed 1.
        do_start(16'h0001);
        chk("busy_rise", busy, 1'b1);
        send_frame(8'h40, 1'b1);
        chk("byte_41", plain_byte, 8'h41);
        expect_out("b1");

        // Second byte with ready held high: one-cycle valid pulse.
        plain_ready = 1'b1;
        send_frame(8'h68, 1'b1);
        chk("byte_00", plain_byte, 8'h00);
        expect_out("b2");
        tick();
        chk("pulse_one", plain_valid, 1'b0);
        plain_ready = 1'b0;

        // Overrun: second byte dropped, keystream keeps advancing.
        send_frame(8'h3C, 1'b0);
        held = q[0];
        expect_out("b3");
        chk("ovr_before", overrun, 1'b0);
        send_frame(8'hC3, 1'b0);
        void'(q.pop_back());
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_held", plain_byte, held);
        chk("ovr_valid", plain_valid, 1'b1);
        accept();
        send_frame(8'h99, 1'b0);
        expect_out("b_sync");
        accept();

        // Zero seed behaves as seed 1; restart mid-byte.
        do_start(16'h0000);
        send_frame(8'h40, 1'b0);
        expect_out("seed0");
        chk("seed0_41", plain_byte, 8'h41);
        accept();
        for (int i = 0; i < 3; i++) begin
            cipher_bit   = i[0];
            cipher_valid = 1'b1;
            tick();
        end
        cipher_valid = 1'b0;
        do_start(16'hACE1);
        send_frame(8'h5A, 1'b1);
        expect_out("restart");
        accept();

        // IDLE ignores cipher_valid; flags survive stop.
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("busy_fall", busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cipher_bit   = 1'b1;
            cipher_valid = 1'b1;
            tick();
        end
        cipher_valid = 1'b0;
        tick();
        chk("idle_nout", plain_valid, 1'b0);
        chk("ovr_sticky", overrun, 1'b1);

        // Reset mid-byte drops the partial byte.
        do_start(16'h0001);
        for (int i = 0; i < 3; i++) begin
            cipher_bit   = 1'b1;
            cipher_valid = 1'b1;
            tick();
        end
        cipher_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_valid", plain_valid, 1'b0);
        chk("mrst_byte", plain_byte, 8'h00);
        chk("mrst_ovr", overrun, 1'b0);
        reset = 1'b0;
        do_start(16'h0001);
        send_frame(8'h40, 1'b1);
        expect_out("post_rst");
        chk("post_rst_41", plain_byte, 8'h41);
        accept();

`ifdef OTP_PARITY_EN
        chk("par_ok", parity_err, 1'b0);
        m_pbad = 1'b1;
        send_frame(8'hA7, 1'b0);
        m_pbad = 1'b0;
        expect_out("par_bad_byte");
        chk("par_set", parity_err, 1'b1);
        accept();
        send_frame(8'h12, 1'b0);
        expect_out("par_next");
        accept();
        chk("par_sticky", parity_err, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("par_clr", parity_err, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
